// File: rtl/spi_slave_regfile_if.sv
// Pin and register-file access bundle for the SPI responder.
// The slave modport is the DUT view; the master modport is the bench or SoC view.
interface spi_slave_regfile_if #(
  parameter int REG_ADDR_W = 8
);
  logic                  spi_clk;
  logic                  sl;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic                  wr_valid;
  logic [15:0]           wr_addr;
  logic [15:0]           wr_data;
  logic                  frame_err;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [15:0]           rd_data;

  modport slave (
    input  spi_clk, sl, mosi, rd_addr,
    output miso, miso_oe, wr_valid, wr_addr, wr_data, frame_err, rd_data
  );

  modport master (
    output spi_clk, sl, mosi, rd_addr,
    input  miso, miso_oe, wr_valid, wr_addr, wr_data, frame_err, rd_data
  );
endinterface

// File: rtl/spi_slave_regfile.sv
// Mode-3, LSB-first SPI responder: 4-byte frames (addr16, data16) commit into a
// 16-bit register file; the previous register contents are returned on miso.
module spi_slave_regfile #(
  parameter int REG_ADDR_W  = 8,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic                clk40M,
  input  logic                rst,
  spi_slave_regfile_if.slave  bus
);

  localparam int             DEPTH = 1 << REG_ADDR_W;
  localparam logic [7:0]     WARM  = 8'(SYNC_STAGES);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_sl_sync, r_mosi_sync;
  logic                   r_sck_d, r_sl_d;
  logic [7:0]             r_warm;
  logic                   r_armed;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [15:0] r_addr, r_data, r_tx;
  logic        r_overrun, r_commit;
  logic        r_miso, r_miso_oe, r_wr_valid, r_frame_err;
  logic [15:0] r_wr_addr, r_wr_data;
  logic [15:0] r_mem [DEPTH];

  logic        w_sck, w_sl, w_mosi;
  logic        w_sck_rise, w_sck_fall, w_sl_fall, w_sl_rise;
  logic [15:0] w_addr_full, w_tx_load;
  logic        w_addr_in_range, w_wr_in_range;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_sl       = r_sl_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = ~r_sck_d & w_sck;
  assign w_sck_fall = r_sck_d & ~w_sck;
  assign w_sl_fall  = r_armed & r_sl_d & ~w_sl;
  assign w_sl_rise  = ~r_sl_d & w_sl;

  // Address as it stands once bit 15 (the current mosi sample) is included.
  assign w_addr_full     = {w_mosi, r_addr[14:0]};
  assign w_addr_in_range = (w_addr_full >> REG_ADDR_W) == 16'd0;
  assign w_tx_load       = w_addr_in_range ? r_mem[w_addr_full[REG_ADDR_W-1:0]] : 16'h0000;
  assign w_wr_in_range   = (r_wr_addr >> REG_ADDR_W) == 16'd0;

  // Synchronizers preset to the idle pattern. A frame may only start once sl
  // has been seen high after reset, so a reset mid-frame drops the remainder.
  always_ff @(posedge clk40M) begin
    if (rst) begin
      r_sck_sync  <= '1;
      r_sl_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b1;
      r_sl_d      <= 1'b1;
      r_warm      <= 8'd0;
      r_armed     <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.spi_clk};
      r_sl_sync   <= {r_sl_sync[SYNC_STAGES-2:0], bus.sl};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_sck_d     <= w_sck;
      r_sl_d      <= w_sl;
      if (r_warm != WARM) r_warm <= r_warm + 8'd1;
      if (r_warm == WARM && w_sl) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk40M) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 6'd0;
      r_addr      <= 16'h0000;
      r_data      <= 16'h0000;
      r_tx        <= 16'h0000;
      r_overrun   <= 1'b0;
      r_commit    <= 1'b0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= 16'h0000;
      r_wr_data   <= 16'h0000;
      r_frame_err <= 1'b0;
    end else begin
      r_commit    <= 1'b0;
      r_wr_valid  <= r_commit;
      r_frame_err <= 1'b0;
      r_miso_oe   <= r_armed & ~w_sl;
      if (r_commit) begin
        r_wr_addr <= r_addr;
        r_wr_data <= r_data;
      end
      if (w_sl_rise) begin
        r_miso      <= 1'b0;
        r_frame_err <= (r_state == S_ADDR) || (r_state == S_DATA) ||
                       ((r_state == S_DONE) && r_overrun);
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_sl_fall) begin
              r_state   <= S_ADDR;
              r_cnt     <= 6'd0;
              r_miso    <= 1'b0;
              r_overrun <= 1'b0;
            end
          end
          S_ADDR: begin
            if (w_sck_rise) begin
              r_addr[r_cnt[3:0]] <= w_mosi;
              r_cnt              <= r_cnt + 6'd1;
              if (r_cnt == 6'd15) begin
                r_tx    <= w_tx_load;
                r_state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (w_sck_rise) begin
              r_data[r_cnt[3:0]] <= w_mosi;
              r_cnt              <= r_cnt + 6'd1;
              if (r_cnt == 6'd31) begin
                r_commit <= 1'b1;
                r_state  <= S_DONE;
              end
            end else if (w_sck_fall) begin
              r_miso <= r_tx[0];
              r_tx   <= r_tx >> 1;
            end
          end
          S_DONE: begin
            if (w_sck_rise) begin
              r_overrun <= 1'b1;
              if (r_cnt != 6'd32) r_cnt <= r_cnt + 6'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // The write lands at the end of the wr_valid cycle, so readback during that
  // cycle (miso or rd_data) still sees the old contents.
  always_ff @(posedge clk40M) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 16'h0000;
    end else if (r_wr_valid && w_wr_in_range) begin
      r_mem[r_wr_addr[REG_ADDR_W-1:0]] <= r_wr_data;
    end
  end

  assign bus.miso      = r_miso;
  assign bus.miso_oe   = r_miso_oe;
  assign bus.wr_valid  = r_wr_valid;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.frame_err = r_frame_err;
  assign bus.rd_data   = r_mem[bus.rd_addr];

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- SPI responder for the 4-byte frame format driven by the team's SPI master: mode 3 (CPOL=1, CPHA=1), LSB first, one frame per active-low chip select. Byte order is addrLsb, addrMsb, dataLsb, dataMsb.
- Oversamples the SPI pins on clk40M and commits each complete frame into a 16-bit register file.
- During the data phase it returns the addressed register's previous contents on miso.
- Used as a device model on the bench and as an on-chip slave target.

Parameters:
- REG_ADDR_W, 8: register file index width. Depth = 2**REG_ADDR_W.
- SYNC_STAGES, 2: synchronizer depth on spi_clk, sl and mosi. Must be >= 2.

Ports:
- clk40M  in  1  system clock. All logic is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- spi_clk  in  1  SPI clock from the master; idles high.
- sl  in  1  chip select, active low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- miso_oe  out  1  output enable for miso; high while sl is synchronised low.
- wr_valid  out  1  one-cycle pulse when a frame commits.
- wr_addr  out  16  full 16-bit address of the committed frame.
- wr_data  out  16  data of the committed frame.
- frame_err  out  1  one-cycle pulse on a bad frame.
- rd_addr  in  REG_ADDR_W  local combinational read index.
- rd_data  out  16  register file contents at rd_addr.

Behaviour:
- Decided interface: one clock; reset is synchronous and active-high.
- Reset values:
  - miso=0, miso_oe=0, wr_valid=0, wr_addr=0, wr_data=0, frame_err=0.
  - All register file entries = 0.
  - State = IDLE, bit counter = 0.
  - Synchronizers preset to the idle pattern (spi_clk=1, sl=1).
- Input sampling: spi_clk, sl and mosi pass through SYNC_STAGES flops. Edge detect compares the last synchronised stage with a one-cycle delayed copy. Masters must use CLKS_PER_HALF_BIT >= 4.
- Bit timing:
  - A synchronised spi_clk rising edge with sl low samples mosi into bit[cnt]. Bits go LSB first: frame bit n is word bit n.
  - A synchronised falling edge updates miso.
- Counter: a 6-bit bit counter is cleared on the sl falling edge and saturates at 32.
- States:
  - IDLE: sl falling edge -> ADDR, cnt=0, miso=0.
  - ADDR: sample bits 0-15 into addr. On the rising edge of bit 15:
    - latch tx_shift = reg[addr[REG_ADDR_W-1:0]] if addr[15:REG_ADDR_W]==0, else 0x0000;
    - go to DATA.
    - miso stays 0 throughout the address phase.
  - DATA:
    - Each falling edge drives miso = tx_shift[0], then shifts tx_shift right.
    - Rising edges sample bits 16-31 into data.
    - On the rising edge of bit 31, pulse wr_valid the next clk40M cycle with wr_addr=addr and wr_data=data.
    - If the address is in range, write the register in that same cycle; out-of-range addresses are reported but not stored.
    - Then go to DONE.
  - DONE: further rising edges are ignored and set an overrun flag. miso holds its last value.
    - On the sl rising edge: pulse frame_err if overrun, then go to IDLE.
- Short frame: an sl rising edge in ADDR or DATA pulses frame_err, performs no write and no wr_valid, and goes to IDLE.
- sl rising edge in any state forces miso_oe=0 and miso=0 on the next cycle.
- Read-during-write: DATA readback always returns the value before the current frame's write.
  - rd_data is combinational on the array and shows the new value from the cycle after wr_valid.
- Read/write precedence: a local rd_addr equal to the written index in the commit cycle returns the old value.
- Reset mid-frame (rst high while sl low):
  - return to reset values;
  - ignore the rest of that frame until sl goes high, then low again.
- Latency: wr_valid asserts SYNC_STAGES+2 clk40M cycles after the 32nd physical spi_clk rising edge.

Test Plan:
1. Reset, then one frame with bytes 0x30,0x00,0x01,0x00 at 16 clk40M per bit -> single wr_valid with wr_addr=0x0030, wr_data=0x0001; rd_addr=0x30 gives rd_data=0x0001; frame_err stays 0.
2. Write 0x00F9/0xC007, then write 0x00F9/0x0000 -> miso over bits 16-31 of the second frame, assembled LSB first, equals 0xC007; afterwards rd_data[0xF9]=0x0000.
3. Frame with sl released after 20 bits (addr 0x0033) -> frame_err pulses once, no wr_valid, reg[0x33] still 0.
4. Frame with 40 clocks (addr 0x00A2, data 0x0001) -> wr_valid after bit 31 with data 0x0001, then frame_err at sl rise; reg[0xA2]=0x0001.
5. Address 0x0130, data 0x1234 -> wr_valid with wr_addr=0x0130, wr_data=0x1234; miso returns 0x0000; reg[0x30] unchanged.
6. Assert rst for 1 cycle at bit 10 of a frame, then complete that frame and send a clean frame 0x0038/0x0001 -> no write from the interrupted frame; the clean frame commits reg[0x38]=0x0001.
